// File: rtl/reset_strategy_core.sv
// reset_strategy_core: free-running counter whose internal reset release is tailored per
// FPGA family and reset strategy. Assertion is always immediate; release is direct or synchronized.
`timescale 1ns/1ps

module reset_strategy_core #(
    parameter string FPGA_FAMILY = "Xilinx",
    parameter string RESET_TYPE  = "synchronous",
    parameter int    WIDTH       = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] counter,
    output logic             reset_done
);

    localparam bit FAMILY_OK = (FPGA_FAMILY == "Xilinx") || (FPGA_FAMILY == "Intel") ||
                               (FPGA_FAMILY == "Lattice");
    localparam bit TYPE_OK   = (RESET_TYPE == "synchronous") || (RESET_TYPE == "asynchronous");
    localparam bit SYNC_MODE = (RESET_TYPE == "synchronous");
    localparam int SYNC_STAGES = (FPGA_FAMILY == "Intel") ? 3 : 2;

    generate
        if (!FAMILY_OK) begin : g_bad_family
            $fatal(1, "reset_strategy_core: illegal FPGA_FAMILY \"%s\"", FPGA_FAMILY);
        end
        if (!TYPE_OK) begin : g_bad_type
            $fatal(1, "reset_strategy_core: illegal RESET_TYPE \"%s\"", RESET_TYPE);
        end
        if (WIDTH < 1) begin : g_bad_width
            $fatal(1, "reset_strategy_core: illegal WIDTH %0d, must be >= 1", WIDTH);
        end
    endgenerate

    logic rst_int_n;

    generate
        if (SYNC_MODE) begin : g_sync
            if (FPGA_FAMILY == "Xilinx") begin : g_xilinx
                (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

                // NOTE: every synchronizer stage is cleared asynchronously so assertion never waits
                // for a clock; only the release is retimed by shifting ones through the chain.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        sync_q <= '0;
                    end else begin
                        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
                    end
                end

                assign rst_int_n = sync_q[SYNC_STAGES-1];
            end else begin : g_generic
                logic [SYNC_STAGES-1:0] sync_q;

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        sync_q <= '0;
                    end else begin
                        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
                    end
                end

                assign rst_int_n = sync_q[SYNC_STAGES-1];
            end
        end else begin : g_async
            assign rst_int_n = rst;
        end
    endgenerate

    // In synchronous mode rst_int_n falls within clk-to-q of rst, so the clear stays immediate.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            counter    <= '0;
            reset_done <= 1'b0;
        end else begin
            counter    <= counter + WIDTH'(1);
            reset_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reset_strategy_core.sv
// Bench for reset_strategy_core: four configurations share clk and rst; expected outputs
// come from a hand table and a small release-latency model, matched through a scoreboard queue.
`timescale 1ns/1ps

module tb_reset_strategy_core;

    typedef struct packed {
        logic       rst_v;
        logic [3:0] c_xa;   // Xilinx asynchronous
        logic [3:0] c_xs;   // Xilinx synchronous
        logic [3:0] c_is;   // Intel synchronous
        logic [3:0] c_ls;   // Lattice synchronous
        logic [3:0] d;      // reset_done bits {xa, xs, is, ls}
    } vec_t;

    logic       clk;
    logic       rst;
    logic       clk_run;
    logic [3:0] cnt_xa, cnt_xs, cnt_is, cnt_ls;
    logic       done_xa, done_xs, done_is, done_ls;

    int   total;
    int   bad;
    vec_t sb [$];
    vec_t tbl [6];

    reset_strategy_core #(.FPGA_FAMILY("Xilinx"), .RESET_TYPE("asynchronous"), .WIDTH(4)) u_xa (
        .clk(clk), .rst(rst), .counter(cnt_xa), .reset_done(done_xa)
    );
    reset_strategy_core #(.FPGA_FAMILY("Xilinx"), .RESET_TYPE("synchronous"), .WIDTH(4)) u_xs (
        .clk(clk), .rst(rst), .counter(cnt_xs), .reset_done(done_xs)
    );
    reset_strategy_core #(.FPGA_FAMILY("Intel"), .RESET_TYPE("synchronous"), .WIDTH(4)) u_is (
        .clk(clk), .rst(rst), .counter(cnt_is), .reset_done(done_is)
    );
    reset_strategy_core #(.FPGA_FAMILY("Lattice"), .RESET_TYPE("synchronous"), .WIDTH(4)) u_ls (
        .clk(clk), .rst(rst), .counter(cnt_ls), .reset_done(done_ls)
    );

    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Edge k after release: zero through edge SYNC_STAGES, then counts (k - stages) mod 16.
    function automatic logic [3:0] exp_cnt(input int k, input int stages);
        return (k <= stages) ? 4'd0 : 4'(k - stages);
    endfunction

    function automatic vec_t model_vec(input int k);
        vec_t v;
        v.rst_v = 1'b1;
        v.c_xa  = exp_cnt(k, 0);
        v.c_xs  = exp_cnt(k, 2);
        v.c_is  = exp_cnt(k, 3);
        v.c_ls  = exp_cnt(k, 2);
        v.d     = {k > 0, k > 2, k > 3, k > 2};
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_cnt_xa"}, 32'(cnt_xa), 0);
        check({tag, "_cnt_xs"}, 32'(cnt_xs), 0);
        check({tag, "_cnt_is"}, 32'(cnt_is), 0);
        check({tag, "_cnt_ls"}, 32'(cnt_ls), 0);
        check({tag, "_done_xa"}, 32'(done_xa), 0);
        check({tag, "_done_xs"}, 32'(done_xs), 0);
        check({tag, "_done_is"}, 32'(done_is), 0);
        check({tag, "_done_ls"}, 32'(done_ls), 0);
    endtask

    task automatic check_out();
        vec_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: got empty queue expected one pending vector");
        end else begin
            total--;
            e = sb.pop_front();
            check("cnt_xa", 32'(cnt_xa), 32'(e.c_xa));
            check("cnt_xs", 32'(cnt_xs), 32'(e.c_xs));
            check("cnt_is", 32'(cnt_is), 32'(e.c_is));
            check("cnt_ls", 32'(cnt_ls), 32'(e.c_ls));
            check("done_xa", 32'(done_xa), 32'(e.d[3]));
            check("done_xs", 32'(done_xs), 32'(e.d[2]));
            check("done_is", 32'(done_is), 32'(e.d[1]));
            check("done_ls", 32'(done_ls), 32'(e.d[0]));
        end
    endtask

    // Drive rst on the falling edge, then sample 1 ns after the following rising edge.
    task automatic drive_row(input vec_t v);
        @(negedge clk);
        rst = v.rst_v;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        clk_run = 1'b0;
        rst     = 1'b1;

        //             rst   xa     xs     is     ls     done
        tbl[0] = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000};
        tbl[1] = '{1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 4'b1000};
        tbl[2] = '{1'b1, 4'd2, 4'd0, 4'd0, 4'd0, 4'b1000};
        tbl[3] = '{1'b1, 4'd3, 4'd1, 4'd0, 4'd1, 4'b1101};
        tbl[4] = '{1'b1, 4'd4, 4'd2, 4'd1, 4'd2, 4'b1111};
        tbl[5] = '{1'b1, 4'd5, 4'd3, 4'd2, 4'd3, 4'b1111};

        // Assertion with no clock running at all.
        #1 rst = 1'b0;
        #2 check_all_zero("reset_hold");
        clk_run = 1'b1;

        for (int i = 0; i < 6; i++) drive_row(tbl[i]);

        // Continue counting through the Lattice wrap (edge 19 reads 1) up to xa = 9 at edge 25.
        for (int k = 6; k <= 25; k++) drive_row(model_vec(k));
        check("precond_xa_nine", 32'(cnt_xa), 9);

        // Mid-period reassertion must clear everything without a clock edge.
        #2 rst = 1'b0;
        #1 check_all_zero("mid_count");

        for (int i = 0; i < 6; i++) drive_row(tbl[i]);

        // Sub-period glitch: outputs clear, then the full release sequence runs again.
        #1 rst = 1'b0;
        #1 check_all_zero("glitch");
        #1 rst = 1'b1;
        for (int i = 1; i < 6; i++) drive_row(tbl[i]);

        check("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
